byte_store_unit: RTL and testbench

BYTE_STORE_UNIT -- requirements
Module: byte_store_unit

---
 rtl/byte_store_unit.sv | 96 +++++++++
 tb/tb_byte_store_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/byte_store_unit.sv
// rtl/byte_store_unit.sv - word/byte store unit with read-merge-write for byte lanes
module byte_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr_en,
    output logic [31:0] mem_wdata,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RD, MRG, WR} state_t;

    state_t      state_q, state_d;
    logic        op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] merged;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // The latched byte replaces lane addr[1:0] of the word read back from memory
    always_comb begin
        merged = mem_rdata;
        merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    addr_d = req_addr;
                    data_d = req_data;
                    if (req_op) begin
                        mem_addr_d = {2'b00, req_addr[31:2]};
                        state_d    = RD;
                    end else begin
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_data;
                        state_d     = WR;
                    end
                end
            end
            RD:  state_d = MRG;
            MRG: begin
                // Word stores never pass through MRG; the op select keeps both paths explicit
                mem_addr_d  = op_q ? {2'b00, addr_q[31:2]} : addr_q;
                mem_wdata_d = op_q ? merged : data_q;
                state_d     = WR;
            end
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_rd_en = (state_q == RD);
    assign mem_wr_en = (state_q == WR);
    assign done      = (state_q == WR);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_byte_store_unit.sv
// tb/tb_byte_store_unit.sv - directed self-checking bench for byte_store_unit
module tb_byte_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic        done;
    logic        busy;

    int total = 0;
    int bad   = 0;

    byte_store_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .done      (done),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        total++;
        if ({req_ready, busy, done, mem_rd_en, mem_wr_en} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 10000", {req_ready, busy, done, mem_rd_en, mem_wr_en});
        end
        total++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: addr=%h wdata=%h want 0/0", mem_addr, mem_wdata);
        end
    endtask

    task automatic test_word(input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1; req_op = 1'b0; req_addr = addr; req_data = data;
        tick();
        req_valid = 1'b0;
        total++;
        if ({mem_wr_en, done, mem_rd_en, busy, req_ready} !== 5'b11010) begin
            bad++;
            $display("FAIL word_wr_ctrl: got %b want 11010", {mem_wr_en, done, mem_rd_en, busy, req_ready});
        end
        total++;
        if (mem_addr !== addr || mem_wdata !== data) begin
            bad++;
            $display("FAIL word_wr_data: addr=%h wdata=%h want %h/%h", mem_addr, mem_wdata, addr, data);
        end
        tick();
        total++;
        if ({mem_wr_en, done, mem_rd_en, busy, req_ready} !== 5'b00001) begin
            bad++;
            $display("FAIL word_idle: got %b want 00001", {mem_wr_en, done, mem_rd_en, busy, req_ready});
        end
    endtask

    task automatic test_byte(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] rdata,
                             input logic [31:0] exp_wdata, input bit churn);
        logic [31:0] exp_addr;
        exp_addr = {2'b00, addr[31:2]};
        req_valid = 1'b1; req_op = 1'b1; req_addr = addr; req_data = data; mem_rdata = rdata;
        tick();
        req_valid = 1'b0;
        if (churn) begin
            req_data = 32'h0; req_addr = 32'h3; req_op = 1'b0;
        end
        total++;
        if ({mem_rd_en, mem_wr_en, done, busy} !== 4'b1001 || mem_addr !== exp_addr) begin
            bad++;
            $display("FAIL byte_rd: ctrl=%b addr=%h want 1001/%h", {mem_rd_en, mem_wr_en, done, busy}, mem_addr, exp_addr);
        end
        tick();
        if (churn) req_valid = 1'b1;
        total++;
        if ({mem_rd_en, mem_wr_en, done, busy} !== 4'b0001 || mem_addr !== exp_addr) begin
            bad++;
            $display("FAIL byte_mrg: ctrl=%b addr=%h want 0001/%h", {mem_rd_en, mem_wr_en, done, busy}, mem_addr, exp_addr);
        end
        tick();
        if (churn) req_valid = 1'b0;
        total++;
        if ({mem_rd_en, mem_wr_en, done, busy} !== 4'b0111 || mem_addr !== exp_addr || mem_wdata !== exp_wdata) begin
            bad++;
            $display("FAIL byte_wr: ctrl=%b addr=%h wdata=%h want 0111/%h/%h",
                     {mem_rd_en, mem_wr_en, done, busy}, mem_addr, mem_wdata, exp_addr, exp_wdata);
        end
        tick();
        total++;
        if ({req_ready, busy, mem_wr_en} !== 3'b100) begin
            bad++;
            $display("FAIL byte_idle: got %b want 100", {req_ready, busy, mem_wr_en});
        end
    endtask

    task automatic test_back_to_back();
        int low_cycles;
        low_cycles = 0;
        req_valid = 1'b1; req_op = 1'b1; req_addr = 32'h0000_0041; req_data = 32'h0000_00C3;
        mem_rdata = 32'h0F0F_0F0F;
        tick();
        for (int i = 0; i < 6 && !req_ready; i++) begin
            low_cycles++;
            if (done) begin
                req_addr = 32'h0000_0082; req_data = 32'h0000_003C;
            end
            tick();
        end
        total++;
        if (low_cycles != 3) begin
            bad++;
            $display("FAIL b2b_gap: ready low %0d cycles want 3", low_cycles);
        end
        tick();
        req_valid = 1'b0;
        total++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 32'h0000_0020) begin
            bad++;
            $display("FAIL b2b_second_rd: rd=%b addr=%h want 1/00000020", mem_rd_en, mem_addr);
        end
        tick();
        tick();
        total++;
        if (mem_wr_en !== 1'b1 || mem_wdata !== 32'h0F3C_0F0F) begin
            bad++;
            $display("FAIL b2b_second_wr: wr=%b wdata=%h want 1/0f3c0f0f", mem_wr_en, mem_wdata);
        end
        tick();
    endtask

    task automatic test_reset_in_mrg();
        bit saw_wr;
        saw_wr = 1'b0;
        req_valid = 1'b1; req_op = 1'b1; req_addr = 32'h0000_0005; req_data = 32'h0000_0099;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        req_valid = 1'b0;
        tick();
        total++;
        if (busy !== 1'b1 || mem_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL rst_pre_mrg: busy=%b rd=%b want 1/0", busy, mem_rd_en);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, busy, done, mem_rd_en, mem_wr_en} !== 5'b10000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_mrg_imm: ctrl=%b addr=%h wdata=%h want 10000/0/0",
                     {req_ready, busy, done, mem_rd_en, mem_wr_en}, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (mem_wr_en) saw_wr = 1'b1;
            tick();
        end
        total++;
        if (saw_wr) begin
            bad++;
            $display("FAIL rst_no_write: got write pulse want none");
        end
        test_word(32'h0000_0100, 32'hCAFE_F00D);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0;
        req_addr = '0; req_data = '0; mem_rdata = '0;
        #2;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_word(32'h0000_0010, 32'hDEAD_BEEF);
        test_byte(32'h0000_000E, 32'hFFFF_FFA5, 32'h1122_3344, 32'h11A5_3344, 1'b0);
        test_byte(32'h0000_0020, 32'h0000_005A, 32'h0, 32'h0000_005A, 1'b0);
        test_byte(32'h0000_0021, 32'h0000_005A, 32'h0, 32'h0000_5A00, 1'b0);
        test_byte(32'h0000_0022, 32'h0000_005A, 32'h0, 32'h005A_0000, 1'b0);
        test_byte(32'h0000_0023, 32'h0000_005A, 32'h0, 32'h5A00_0000, 1'b0);
        test_byte(32'hFFFF_FFFF, 32'h0000_0011, 32'h0, 32'h1100_0000, 1'b0);
        test_back_to_back();
        test_byte(32'h0000_0001, 32'hFFFF_FF77, 32'hAAAA_AAAA, 32'hAAAA_77AA, 1'b1);
        test_reset_in_mrg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
